mem_access_unit: RTL

- Multi-cycle initiator that sits between the CPU datapath and the word-addressed data memory.
- Accepts one load/store request per handshake and performs sub-word loads with sign/zero extension.
- Performs sub-word stores (SH/SB) by read-modify-write, since the DM port is word-wide only.
- Flags misaligned and out-of-range addresses without touching DM.

---
 rtl/mem_access_if.sv | 28 ++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Bus bundle between the CPU datapath, the memory access unit and the word-wide data memory.
// The unit uses the slave view; the surrounding CPU/DM environment uses the master view.
interface mem_access_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        addr_err;
   logic [31:0] dm_A;
   logic        dm_WE;
   logic [31:0] dm_WD;
   logic [31:0] dm_pc;
   logic [31:0] dm_RD;

   modport slave (
      input  req, op, addr, wdata, pc, dm_RD,
      output busy, done, rdata, addr_err, dm_A, dm_WE, dm_WD, dm_pc
   );

   modport master (
      output req, op, addr, wdata, pc, dm_RD,
      input  busy, done, rdata, addr_err, dm_A, dm_WE, dm_WD, dm_pc
   );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator for a word-wide data memory: sub-word loads with extension,
// sub-word stores by read-modify-write, and address checking before any DM access.
module mem_access_unit #(
   parameter int DM_WORDS = 3072
) (
   input  logic         clk,
   input  logic         reset,
   mem_access_if.slave  bus
);
   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state_r;
   logic [2:0]  op_r;
   logic [1:0]  lane_r;
   logic [15:0] wdata_r;
   logic        busy_r;
   logic        done_r;
   logic [31:0] rdata_r;
   logic        addr_err_r;
   logic [29:0] dm_a_r;
   logic        dm_we_r;
   logic [31:0] dm_wd_r;
   logic [31:0] dm_pc_r;
   logic        misalign_s;
   logic        range_err_s;
   logic        acc_err_s;

   function automatic logic [31:0] load_extend(input logic [2:0] o, input logic [1:0] a,
                                               input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         2'd3:    b = rd[31:24];
         default: b = 8'h00;
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      case (o)
         OP_LW:   r = rd;
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0000, h};
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h000000, b};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Replace only the addressed lane of the word read back from DM.
   function automatic logic [31:0] store_merge(input logic [2:0] o, input logic [1:0] a,
                                               input logic [31:0] rd, input logic [15:0] wd);
      logic [31:0] r;
      r = rd;
      case (o)
         OP_SH: begin
            if (a[1]) r[31:16] = wd;
            else      r[15:0]  = wd;
         end
         OP_SB: begin
            case (a)
               2'd0:    r[7:0]   = wd[7:0];
               2'd1:    r[15:8]  = wd[7:0];
               2'd2:    r[23:16] = wd[7:0];
               2'd3:    r[31:24] = wd[7:0];
               default: r = rd;
            endcase
         end
         default: r = rd;
      endcase
      return r;
   endfunction

   // Alignment and range check of the request presented on the bus.
   always_comb begin
      misalign_s = 1'b0;
      case (bus.op)
         OP_LW, OP_SW:         misalign_s = (bus.addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: misalign_s = bus.addr[0];
         default:              misalign_s = 1'b0;
      endcase
      range_err_s = (bus.addr >= ADDR_LIMIT);
      acc_err_s   = misalign_s | range_err_s;
   end

   // Access sequencer with all bus outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         op_r       <= 3'd0;
         lane_r     <= 2'd0;
         wdata_r    <= 16'h0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rdata_r    <= 32'h0000_0000;
         addr_err_r <= 1'b0;
         dm_a_r     <= 30'h0000_0000;
         dm_we_r    <= 1'b0;
         dm_wd_r    <= 32'h0000_0000;
         dm_pc_r    <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.req) begin
                  op_r    <= bus.op;
                  lane_r  <= bus.addr[1:0];
                  wdata_r <= bus.wdata[15:0];
                  dm_pc_r <= bus.pc;
                  busy_r  <= 1'b1;
                  if (acc_err_s) begin
                     state_r    <= DONE;
                     done_r     <= 1'b1;
                     addr_err_r <= 1'b1;
                     rdata_r    <= 32'h0000_0000;
                  end else begin
                     dm_a_r <= bus.addr[31:2];
                     if (bus.op == OP_SW) begin
                        state_r <= WRITE;
                        dm_we_r <= 1'b1;
                        dm_wd_r <= bus.wdata;
                     end else begin
                        state_r <= READ;
                     end
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            READ: begin
               if (op_r == OP_SH || op_r == OP_SB) begin
                  state_r <= WRITE;
                  dm_we_r <= 1'b1;
                  dm_wd_r <= store_merge(op_r, lane_r, bus.dm_RD, wdata_r);
               end else begin
                  state_r    <= DONE;
                  done_r     <= 1'b1;
                  addr_err_r <= 1'b0;
                  rdata_r    <= load_extend(op_r, lane_r, bus.dm_RD);
               end
            end
            WRITE: begin
               state_r    <= DONE;
               dm_we_r    <= 1'b0;
               done_r     <= 1'b1;
               addr_err_r <= 1'b0;
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               dm_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.rdata    = rdata_r;
   assign bus.addr_err = addr_err_r;
   assign bus.dm_A     = {dm_a_r, 2'b00};
   // Reset must suppress a write already in flight in the same cycle.
   assign bus.dm_WE    = dm_we_r & ~reset;
   assign bus.dm_WD    = dm_wd_r;
   assign bus.dm_pc    = dm_pc_r;
endmodule
